if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the consumer of the PC register's fetch interface.
- Takes `pc_i`, `pc_enable_i` and `pc_jump_i`; returns `icache_hitted_o` and `inst_ready_o`, which the PC register uses to advance or redirect.
- Holds a direct-mapped instruction cache; on a miss it runs a word-read handshake with the memory controller.
- Delivers a registered (pc, inst, valid) triple to ID.

Parameters:
- ADDR_LEN, 32, address width.
- INST_LEN, 32, instruction width.
- IDX_BITS, 7, cache index bits (128 one-word lines); tag = pc[ADDR_LEN-1:IDX_BITS+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- stall_i  in  1  pipeline stall from control
- pc_enable_i  in  1  PC valid from PC register
- pc_i  in  ADDR_LEN  fetch address
- pc_jump_i  in  1  redirect in progress (PC loads target this edge)
- icache_hitted_o  out  1  combinational cache hit
- inst_ready_o  out  1  combinational: miss data delivered this cycle
- mem_req_o  out  1  read request to memory controller
- mem_addr_o  out  ADDR_LEN  request address
- mem_ready_i  in  1  one-cycle pulse, mem_inst_i valid
- mem_inst_i  in  INST_LEN  fetched word
- if_valid_o  out  1  to ID: instruction valid
- if_pc_o  out  ADDR_LEN  to ID: instruction PC
- if_inst_o  out  INST_LEN  to ID: instruction

Behaviour:
- Reset:
  - All valid bits cleared; state IDLE.
  - `mem_req_o`, `if_valid_o` = 0; `mem_addr_o`, `if_pc_o`, `if_inst_o` = 0.
  - Reset mid-miss abandons the request immediately.
- `rdy` = 0: no register changes; `mem_req_o` holds.
- States: IDLE, WAIT_MEM, DISCARD.
- `icache_hitted_o` = IDLE && `pc_enable_i` && valid[idx] && tag match. It is not gated by stall.
- `inst_ready_o` = WAIT_MEM && `mem_ready_i` && !`stall_i` && !`pc_jump_i`.
- IDLE, in priority order:
  - `pc_jump_i`: `if_valid_o` <= 0; no request issued.
  - `stall_i`: ID outputs hold.
  - Hit: `if_pc_o` <= `pc_i`, `if_inst_o` <= line data, `if_valid_o` <= 1. Zero-bubble back-to-back hits.
  - Miss with `pc_enable_i`: `mem_req_o` <= 1, `mem_addr_o` <= `pc_i`, `if_valid_o` <= 0, go to WAIT_MEM.
- WAIT_MEM:
  - `mem_req_o` and `mem_addr_o` are held until `mem_ready_i`.
  - On `mem_ready_i`:
    - Write line (tag from `mem_addr_o`, set valid) and drop `mem_req_o`.
    - Go to IDLE.
    - If `inst_ready_o`, also load ID outputs with `mem_addr_o`/`mem_inst_i` and set `if_valid_o` = 1.
  - Same-cycle `stall_i` or `pc_jump_i` with `mem_ready_i`: cache is filled but nothing is delivered. The re-fetch later hits.
  - `pc_jump_i` without `mem_ready_i`: `if_valid_o` <= 0, go to DISCARD.
- DISCARD:
  - The in-flight request is never cancelled; `mem_req_o` is held.
  - On `mem_ready_i`: fill line, drop request, go to IDLE, deliver nothing.
  - Further jumps are ignored.
- Fill/lookup same index same cycle: the lookup sees the old contents; the write wins at the edge.
- Instruction addresses are word-aligned; pc[1:0] is ignored.

Optional Feature:
- IF_ICACHE_EN
  - Defined: cache as above.
  - Undefined: no tag/data arrays; `icache_hitted_o` is tied to 0; every fetch takes the miss path, fills are skipped.

Decomposition:
- Shared package/defines: `AddrLen`, `InstLen`, `ZERO_WORD`, `Enable`/`Disable`, state encodings (IDLE=2'd0, WAIT_MEM=2'd1, DISCARD=2'd2).
- One sub-module, `icache_dm`: arrays, combinational lookup (hit, data), synchronous write port, synchronous clear on `rst`.

Test Plan:
- Cold miss at pc 0x0 → `mem_req_o`=1, `mem_addr_o`=0x0; `mem_ready_i` with 0x00000013 at cycle 4 → `inst_ready_o`=1 that cycle; next cycle `if_pc_o`=0x0, `if_inst_o`=0x13, `if_valid_o`=1.
- Re-fetch 0x0 after fill → `icache_hitted_o`=1 in the same cycle, `if_valid_o`=1 next edge, no `mem_req_o`; 4 sequential hits → 4 consecutive valid outputs.
- Miss at 0x100, `pc_jump_i` pulsed (target 0x200) before `mem_ready_i` → DISCARD, `if_valid_o`=0; `mem_ready_i` returns → no delivery; 0x100 then hits; 0x200 issues a new request.
- Alias: 0x000 and 0x200 (IDX_BITS=7) fetched alternately → both always miss; second fill overwrites the line.
- `stall_i` high when `mem_ready_i` arrives → `inst_ready_o`=0, ID outputs unchanged; after stall release, same pc hits.
- `rst` asserted during WAIT_MEM → next cycle `mem_req_o`=0, `if_valid_o`=0; earlier-cached pc misses.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The I-cache is built only when IF_ICACHE_EN is defined.
package if_fetch_unit_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam int IdxBits = 7;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;
    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache.
// Lookup is combinational; the fill port writes at the clock edge.
import if_fetch_unit_pkg::*;

module icache_dm #(
    parameter int ADDR_LEN = AddrLen,
    parameter int INST_LEN = InstLen,
    parameter int IDX_BITS = IdxBits
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_LEN-3:0] rd_word,
    output logic                hit,
    output logic [INST_LEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [ADDR_LEN-3:0] wr_word,
    input  logic [INST_LEN-1:0] wr_data
);

    localparam int TagLen = ADDR_LEN - 2 - IDX_BITS;
    localparam int Lines  = 1 << IDX_BITS;

    logic [Lines-1:0]    valid;
    logic [TagLen-1:0]   tags [Lines];
    logic [INST_LEN-1:0] data [Lines];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TagLen-1:0]   rd_tag;
    logic [TagLen-1:0]   wr_tag;

    assign rd_idx = rd_word[IDX_BITS-1:0];
    assign rd_tag = rd_word[ADDR_LEN-3:IDX_BITS];
    assign wr_idx = wr_word[IDX_BITS-1:0];
    assign wr_tag = wr_word[ADDR_LEN-3:IDX_BITS];

    // Lookup sees pre-edge contents even when a fill targets the same line
    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_data = data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (rdy && wr_en) begin
            valid[wr_idx] <= Enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: I-cache lookup, miss handshake, IF/ID register.
// Define IF_ICACHE_EN to build the cache; otherwise every fetch misses.
import if_fetch_unit_pkg::*;

module if_fetch_unit #(
    parameter int ADDR_LEN = AddrLen,
    parameter int INST_LEN = InstLen,
    parameter int IDX_BITS = IdxBits
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                stall_i,
    input  logic                pc_enable_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                pc_jump_i,
    output logic                icache_hitted_o,
    output logic                inst_ready_o,
    output logic                mem_req_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_ready_i,
    input  logic [INST_LEN-1:0] mem_inst_i,
    output logic                if_valid_o,
    output logic [ADDR_LEN-1:0] if_pc_o,
    output logic [INST_LEN-1:0] if_inst_o
);

    fetch_state_e state, state_n;

    logic                req_n;
    logic [ADDR_LEN-1:0] addr_n;
    logic                valid_n;
    logic [ADDR_LEN-1:0] pc_n;
    logic [INST_LEN-1:0] inst_n;

    logic                cache_hit;
    logic [INST_LEN-1:0] cache_data;
    logic                fill;

    assign fill = (state != IDLE) && mem_ready_i;

`ifdef IF_ICACHE_EN
    icache_dm #(
        .ADDR_LEN(ADDR_LEN),
        .INST_LEN(INST_LEN),
        .IDX_BITS(IDX_BITS)
    ) u_icache (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .rd_word(pc_i[ADDR_LEN-1:2]),
        .hit    (cache_hit),
        .rd_data(cache_data),
        .wr_en  (fill),
        .wr_word(mem_addr_o[ADDR_LEN-1:2]),
        .wr_data(mem_inst_i)
    );
`else
    assign cache_hit  = Disable;
    assign cache_data = '0;
`endif

    assign icache_hitted_o = (state == IDLE) && pc_enable_i && cache_hit;
    assign inst_ready_o    = (state == WAIT_MEM) && mem_ready_i
                           && !stall_i && !pc_jump_i;

    always_comb begin
        state_n = state;
        req_n   = mem_req_o;
        addr_n  = mem_addr_o;
        valid_n = if_valid_o;
        pc_n    = if_pc_o;
        inst_n  = if_inst_o;
        unique case (state)
            IDLE: begin
                if (pc_jump_i) begin
                    valid_n = Disable;
                end else if (stall_i) begin
                    valid_n = if_valid_o;
                end else if (icache_hitted_o) begin
                    pc_n    = pc_i;
                    inst_n  = cache_data;
                    valid_n = Enable;
                end else if (pc_enable_i) begin
                    req_n   = Enable;
                    addr_n  = pc_i;
                    valid_n = Disable;
                    state_n = WAIT_MEM;
                end else begin
                    valid_n = Disable;
                end
            end
            WAIT_MEM: begin
                if (mem_ready_i) begin
                    req_n   = Disable;
                    state_n = IDLE;
                    if (inst_ready_o) begin
                        pc_n    = mem_addr_o;
                        inst_n  = mem_inst_i;
                        valid_n = Enable;
                    end
                end else if (pc_jump_i) begin
                    valid_n = Disable;
                    state_n = DISCARD;
                end
            end
            DISCARD: begin
                // Request stays outstanding; its data only fills the cache
                if (mem_ready_i) begin
                    req_n   = Disable;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req_o  <= Disable;
            mem_addr_o <= '0;
            if_valid_o <= Disable;
            if_pc_o    <= '0;
            if_inst_o  <= ZERO_WORD;
        end else if (rdy) begin
            state      <= state_n;
            mem_req_o  <= req_n;
            mem_addr_o <= addr_n;
            if_valid_o <= valid_n;
            if_pc_o    <= pc_n;
            if_inst_o  <= inst_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; expectations follow IF_ICACHE_EN.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_i;
    logic        pc_enable_i;
    logic [31:0] pc_i;
    logic        pc_jump_i;
    logic        icache_hitted_o;
    logic        inst_ready_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_inst_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int n_asrt = 0;
    int n_fail = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .stall_i        (stall_i),
        .pc_enable_i    (pc_enable_i),
        .pc_i           (pc_i),
        .pc_jump_i      (pc_jump_i),
        .icache_hitted_o(icache_hitted_o),
        .inst_ready_o   (inst_ready_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ready_i    (mem_ready_i),
        .mem_inst_i     (mem_inst_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full miss: request, wait cycles, data return, delivery to ID
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d,
                           input int waits);
        pc_i        = a;
        pc_enable_i = 1'b1;
        #1;
        chk("miss_hit", {31'd0, icache_hitted_o}, 32'd0);
        tick();
        chk("miss_req", {31'd0, mem_req_o}, 32'd1);
        chk("miss_addr", mem_addr_o, a);
        chk("miss_vld", {31'd0, if_valid_o}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            chk("wait_rdy", {31'd0, inst_ready_o}, 32'd0);
            tick();
            chk("wait_req", {31'd0, mem_req_o}, 32'd1);
        end
        mem_ready_i = 1'b1;
        mem_inst_i  = d;
        #1;
        chk("fill_rdy", {31'd0, inst_ready_o}, 32'd1);
        tick();
        mem_ready_i = 1'b0;
        chk("dlv_vld", {31'd0, if_valid_o}, 32'd1);
        chk("dlv_pc", if_pc_o, a);
        chk("dlv_inst", if_inst_o, d);
        chk("dlv_req", {31'd0, mem_req_o}, 32'd0);
    endtask

`ifdef IF_ICACHE_EN
    task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
        pc_i        = a;
        pc_enable_i = 1'b1;
        #1;
        chk("hit_comb", {31'd0, icache_hitted_o}, 32'd1);
        tick();
        chk("hit_vld", {31'd0, if_valid_o}, 32'd1);
        chk("hit_pc", if_pc_o, a);
        chk("hit_inst", if_inst_o, d);
        chk("hit_req", {31'd0, mem_req_o}, 32'd0);
    endtask
`endif

    initial begin
        rst         = 1'b1;
        rdy         = 1'b1;
        stall_i     = 1'b0;
        pc_enable_i = 1'b0;
        pc_i        = '0;
        pc_jump_i   = 1'b0;
        mem_ready_i = 1'b0;
        mem_inst_i  = '0;
        tick();
        tick();
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_vld", {31'd0, if_valid_o}, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x0
        do_miss(32'h0, 32'h0000_0013, 2);

`ifdef IF_ICACHE_EN
        do_miss(32'h4, 32'h0010_0093, 1);
        do_hit(32'h0, 32'h0000_0013);
        do_hit(32'h4, 32'h0010_0093);
        do_hit(32'h0, 32'h0000_0013);
        do_hit(32'h4, 32'h0010_0093);
`else
        do_miss(32'h0, 32'h0000_0013, 0);
`endif

        // Redirect while a miss is outstanding
        pc_i = 32'h100;
        #1;
        chk("j_hit", {31'd0, icache_hitted_o}, 32'd0);
        tick();
        chk("j_req", {31'd0, mem_req_o}, 32'd1);
        chk("j_addr", mem_addr_o, 32'h100);
        pc_jump_i = 1'b1;
        #1;
        chk("j_irdy", {31'd0, inst_ready_o}, 32'd0);
        tick();
        pc_jump_i = 1'b0;
        chk("disc_vld", {31'd0, if_valid_o}, 32'd0);
        chk("disc_req", {31'd0, mem_req_o}, 32'd1);
        pc_i = 32'h200;
        tick();
        chk("disc_addr", mem_addr_o, 32'h100);
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'h0000_aaaa;
        #1;
        chk("disc_irdy", {31'd0, inst_ready_o}, 32'd0);
        tick();
        mem_ready_i = 1'b0;
        chk("disc_drop", {31'd0, mem_req_o}, 32'd0);
        chk("disc_nodlv", {31'd0, if_valid_o}, 32'd0);
`ifdef IF_ICACHE_EN
        do_hit(32'h100, 32'h0000_aaaa);
`endif
        do_miss(32'h200, 32'h0000_0022, 1);

        // Aliasing lines: 0x000 and 0x200 share index 0
        do_miss(32'h0, 32'h0000_0013, 0);
        do_miss(32'h200, 32'h0000_0022, 0);
        do_miss(32'h0, 32'h0000_0013, 1);

        // Stall coincides with returning data
        pc_i = 32'h40;
        #1;
        chk("st_hit", {31'd0, icache_hitted_o}, 32'd0);
        tick();
        chk("st_req", {31'd0, mem_req_o}, 32'd1);
        stall_i     = 1'b1;
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'h0000_0044;
        #1;
        chk("st_irdy", {31'd0, inst_ready_o}, 32'd0);
        tick();
        mem_ready_i = 1'b0;
        stall_i     = 1'b0;
        chk("st_vld", {31'd0, if_valid_o}, 32'd0);
        chk("st_pc", if_pc_o, 32'h0);
        chk("st_inst", if_inst_o, 32'h0000_0013);
        chk("st_req2", {31'd0, mem_req_o}, 32'd0);
`ifdef IF_ICACHE_EN
        do_hit(32'h40, 32'h0000_0044);
`else
        do_miss(32'h40, 32'h0000_0044, 0);
`endif

        // rdy low freezes, then reset mid-miss
        pc_i = 32'h80;
        #1;
        chk("fz_hit", {31'd0, icache_hitted_o}, 32'd0);
        tick();
        chk("fz_req", {31'd0, mem_req_o}, 32'd1);
        rdy         = 1'b0;
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'h0000_0055;
        tick();
        chk("fz_req2", {31'd0, mem_req_o}, 32'd1);
        chk("fz_addr", mem_addr_o, 32'h80);
        chk("fz_pc", if_pc_o, 32'h40);
        mem_ready_i = 1'b0;
        rdy         = 1'b1;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mrst_vld", {31'd0, if_valid_o}, 32'd0);
        chk("mrst_addr", mem_addr_o, 32'd0);
        chk("mrst_pc", if_pc_o, 32'd0);
        do_miss(32'h40, 32'h0000_0044, 1);

        pc_enable_i = 1'b0;
        tick();
        chk("idle_vld", {31'd0, if_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
